dmux_route_seq: RTL
===================

# dmux_route_seq

Upstream sequencer for the 1:4 demultiplexer (`dmux1_4`). It accepts routing requests `{address, data bit}` over a valid/ready handshake and buffers them in a small FIFO. It then presents them one at a time on the demux select `A` and data `din` inputs. Each request is held for a programmable number of cycles, so the demux sees clean, glitch-free, time-sliced routing.

## Interface
- `DEPTH`, default 4: FIFO entries. Must be a power of 2 and ≥2.
- `HOLD`, default 1: cycles each request drives `A`/`din`. Must be ≥1.
- `LW`, default $clog2(DEPTH)+1: width of `level`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  FIFO can accept.
- `in_addr`  in  2  destination demux output index, 0..3.
- `in_data`  in  1  data bit to route.
- `A`  out  2  demux select; connects to `dmux1_4` `A`.
- `din`  out  1  demux data; connects to `dmux1_4` `din`.
- `out_valid`  out  1  `A`/`din` currently carry a live request.
- `level`  out  LW  FIFO occupancy, 0..DEPTH. Excludes the request in the output stage.

## Operation
**FIFO**
- Storage is `DEPTH` × 3 bits, `{addr, data}`, with read and write pointers that wrap modulo `DEPTH`.
- Push occurs on `in_valid && in_ready`.
- `in_ready = (level != DEPTH)`, decoded from the registered `level` only. There is no bypass, so a full FIFO refuses input even when a pop happens in the same cycle.
- Push and pop in the same cycle leave `level` unchanged and update both pointers.
- Push only: `level` +1. Pop only: `level` −1.

**Output FSM**
- State `IDLE`:
  - `out_valid = 0`, `din = 0`, `A` keeps its last value.
  - If `level > 0`: pop the head into `A`/`din`, set `out_valid = 1`, load `cnt = HOLD-1`, go to `DRIVE`.
- State `DRIVE`:
  - If `cnt > 0`: decrement `cnt`.
  - Else if `level > 0`: pop the next head (back-to-back), reload `cnt = HOLD-1`, stay in `DRIVE`.
  - Else: `out_valid = 0`, `din = 0`, go to `IDLE`.
- `A`, `din` and `out_valid` are registered outputs and change only on the edges described above.
- While an item is held, `A` and `din` are stable, so the demux output pattern is stable for exactly `HOLD` cycles.
- When `out_valid = 0`, `din = 0`, so all demux outputs are 0.

**Reset**
- At the next edge with `rst = 1`:
  - pointers = 0, `level` = 0, `in_ready` = 1;
  - `A` = 0, `din` = 0, `out_valid` = 0;
  - FSM = `IDLE`, `cnt` = 0.
- Reset mid-operation flushes all queued and in-flight requests with no partial output.
- Reset has priority over a simultaneous push.

## Timing
- Acceptance at edge E0 (FIFO previously empty, FSM `IDLE`): `level` becomes 1 after E0. The pop at E1 makes `A`/`din`/`out_valid` valid after E1, giving a 1-cycle gap.
- Each request drives the outputs for exactly `HOLD` cycles.
- With the FIFO kept non-empty, requests appear back-to-back: one every `HOLD` cycles, with no `out_valid` gap.
- Throughput with `HOLD = 1`: one request per cycle sustained.
- `in_ready` deasserts in the cycle after the push that fills the FIFO, and reasserts in the cycle after the first pop from full.
- Order is strictly FIFO. Nothing is dropped or duplicated.

## Test plan
- **Reset values:** assert `rst` for 2 cycles with `in_valid = 1`. Expect `A = 0`, `din = 0`, `out_valid = 0`, `level = 0`, `in_ready = 1`, and no push recorded.
- **Single request, `HOLD = 1`:** push `{addr = 2, data = 1}` at E0.
  - After E1: `A = 2`, `din = 1`, `out_valid = 1`, so demux `Y = 4'b0100`.
  - After E2: `out_valid = 0`, `din = 0`, `Y = 0`.
- **Sweep:** push addr 0, 1, 2, 3 with data 1 on consecutive cycles, `HOLD = 1`. Expect `A` = 0, 1, 2, 3 on consecutive cycles starting one cycle after the first push, and `Y` = 0001, 0010, 0100, 1000.
- **`HOLD = 3`:** push `{1,1}` then `{3,0}`.
  - `A = 1`, `din = 1` for exactly 3 cycles.
  - Then `A = 3`, `din = 0`, `out_valid = 1` for 3 cycles.
  - Then `out_valid = 0`.
- **Full / backpressure, `DEPTH = 4`, `HOLD = 3`:** hold `in_valid = 1` continuously.
  - `level` reaches 4 and `in_ready = 0`.
  - No `level` overflow.
  - `in_ready` returns to 1 one cycle after each pop.
  - Pointer wrap-around after 8+ requests still preserves FIFO order.
- **Reset mid-operation:** with `level = 3` and `out_valid = 1`, pulse `rst` for one cycle. Next cycle: `level = 0`, `out_valid = 0`, `din = 0`, `A = 0`. A new push after reset routes correctly.

Source files
------------

// File: rtl/dmux_route_seq.sv
// Routing-request sequencer feeding a 1:4 demux: buffers {addr, data} requests in a FIFO and
// presents each one on A/din for HOLD cycles, with din forced low whenever nothing is live.
module dmux_route_seq #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned HOLD  = 1,
    parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_addr,
    input  logic          in_data,
    output logic [1:0]    A,
    output logic          din,
    output logic          out_valid,
    output logic [LW-1:0] level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [LW-1:0] LevelFull = LW'(DEPTH);
    localparam logic [CW-1:0] CntReload = CW'(HOLD - 1);

    typedef enum logic [0:0] {
        StIdle,
        StDrive
    } state_e;

    state_e state_q, state_d;

    logic [2:0]    mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [LW-1:0] level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    a_q, a_d;
    logic          din_q, din_d;
    logic          valid_q, valid_d;

    logic          push;
    logic          pop;
    logic          has_item;
    logic [2:0]    head;

    // Ready comes from the registered level only, so a full FIFO stalls even on a pop cycle.
    assign in_ready = (level_q != LevelFull);
    assign push     = in_valid && in_ready;
    assign has_item = (level_q != '0);
    assign head     = mem_q[rptr_q];

    // ------------------------------------------------------------------
    // Output FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Output FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (has_item) begin
                    state_d = StDrive;
                end
            end
            StDrive: begin
                if ((cnt_q == '0) && !has_item) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Output FSM: pop decision and next values of the registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        pop     = 1'b0;
        cnt_d   = cnt_q;
        a_d     = a_q;
        din_d   = din_q;
        valid_d = valid_q;
        unique case (state_q)
            StIdle: begin
                valid_d = 1'b0;
                din_d   = 1'b0;
                if (has_item) begin
                    pop           = 1'b1;
                    {a_d, din_d}  = head;
                    valid_d       = 1'b1;
                    cnt_d         = CntReload;
                end
            end
            StDrive: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (has_item) begin
                    pop          = 1'b1;
                    {a_d, din_d} = head;
                    valid_d      = 1'b1;
                    cnt_d        = CntReload;
                end else begin
                    // A keeps its last select so the demux never sees a spurious address change.
                    valid_d = 1'b0;
                    din_d   = 1'b0;
                end
            end
            default: begin
                valid_d = 1'b0;
                din_d   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO occupancy
    // ------------------------------------------------------------------
    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage carries no reset; occupancy and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {in_addr, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            din_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            level_q <= level_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            din_q   <= din_d;
            valid_q <= valid_d;
        end
    end

    assign A         = a_q;
    assign din       = din_q;
    assign out_valid = valid_q;
    assign level     = level_q;

endmodule
